// File: rtl/mac8_fu.sv
// MAC8 execute-stage functional unit: signed int8 dot product across byte lanes,
// with an internal accumulator, two-cycle pipeline and tagged writeback.
module mac8_fu #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned TRANS_ID_BITS = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     mac8_FU_valid_i,
  output logic                     mac8_FU_ready_o,
  input  logic [1:0]               op_i,
  input  logic [XLEN-1:0]          operand_a_i,
  input  logic [XLEN-1:0]          operand_b_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  output logic                     result_valid_o,
  output logic [XLEN-1:0]          result_o,
  output logic [TRANS_ID_BITS-1:0] result_trans_id_o
);

  localparam int unsigned L = XLEN / 8;

  typedef enum logic [1:0] {
    OP_DOT8   = 2'd0,
    OP_MAC8   = 2'd1,
    OP_CLRACC = 2'd2,
    OP_RDACC  = 2'd3
  } op_e;

  logic                     issue;
  logic signed [15:0]       lane_prod [L];

  logic                     s1_valid;
  op_e                      s1_op;
  logic [TRANS_ID_BITS-1:0] s1_id;
  logic signed [15:0]       s1_prod [L];

  logic [XLEN-1:0]          prod_sum;

  logic                     s2_valid;
  op_e                      s2_op;
  logic [TRANS_ID_BITS-1:0] s2_id;
  logic [XLEN-1:0]          s2_dot;

  logic [XLEN-1:0]          acc_q;
  logic [XLEN-1:0]          acc_nxt;
  logic [XLEN-1:0]          res_nxt;
  logic [XLEN-1:0]          mac_sum;

  // Never back-pressures; only unavailable while held in reset.
  assign mac8_FU_ready_o = rst_ni;
  assign issue           = mac8_FU_valid_i & mac8_FU_ready_o;

  always_comb begin
    for (int k = 0; k < L; k++) begin
      lane_prod[k] = $signed(operand_a_i[8*k +: 8]) * $signed(operand_b_i[8*k +: 8]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_DOT8;
      s1_id    <= '0;
      for (int k = 0; k < L; k++) s1_prod[k] <= '0;
    end else begin
      s1_valid <= issue & ~flush_i;
      if (issue) begin
        s1_op <= op_e'(op_i);
        s1_id <= trans_id_i;
        for (int k = 0; k < L; k++) s1_prod[k] <= lane_prod[k];
      end
    end
  end

  // Lane sum cannot exceed L*16384 in magnitude, so sign-extending each product is exact.
  always_comb begin
    prod_sum = '0;
    for (int k = 0; k < L; k++) begin
      prod_sum = prod_sum + {{(XLEN-16){s1_prod[k][15]}}, s1_prod[k]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid <= 1'b0;
      s2_op    <= OP_DOT8;
      s2_id    <= '0;
      s2_dot   <= '0;
    end else begin
      s2_valid <= s1_valid & ~flush_i;
      if (s1_valid) begin
        s2_op  <= s1_op;
        s2_id  <= s1_id;
        s2_dot <= prod_sum;
      end
    end
  end

  always_comb begin
    mac_sum = acc_q + s2_dot;
    res_nxt = acc_q;
    acc_nxt = acc_q;
    unique case (s2_op)
      OP_DOT8:   res_nxt = s2_dot;
      OP_MAC8: begin
        res_nxt = mac_sum;
        acc_nxt = mac_sum;
      end
      OP_CLRACC: acc_nxt = '0;
      OP_RDACC:  res_nxt = acc_q;
      default:   res_nxt = acc_q;
    endcase
  end

  // Accumulator is touched only here, so consecutive MAC8 ops chain without hazards.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_valid_o    <= 1'b0;
      result_o          <= '0;
      result_trans_id_o <= '0;
      acc_q             <= '0;
    end else begin
      result_valid_o <= s2_valid & ~flush_i;
      if (s2_valid && !flush_i) begin
        result_o          <= res_nxt;
        result_trans_id_o <= s2_id;
        acc_q             <= acc_nxt;
      end
    end
  end

endmodule

// File: tb/tb_mac8_fu.sv
// Directed self-checking bench for mac8_fu (XLEN=32): dot products, accumulator
// chaining, wrap/clear, flush and mid-pipe reset.
module tb_mac8_fu;

  localparam int XLEN = 32;
  localparam int TID  = 3;

  localparam logic [1:0] OP_DOT8   = 2'd0;
  localparam logic [1:0] OP_MAC8   = 2'd1;
  localparam logic [1:0] OP_CLRACC = 2'd2;
  localparam logic [1:0] OP_RDACC  = 2'd3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            mac8_valid;
  logic            mac8_ready;
  logic [1:0]      op;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic [TID-1:0]  trans_id;
  logic            result_valid;
  logic [XLEN-1:0] result;
  logic [TID-1:0]  result_trans_id;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [XLEN-1:0] q_data [$];
  logic [TID-1:0]  q_id   [$];
  int              q_cyc  [$];
  int              iss_cyc[$];

  mac8_fu #(.XLEN(XLEN), .TRANS_ID_BITS(TID)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .flush_i           (flush),
    .mac8_FU_valid_i   (mac8_valid),
    .mac8_FU_ready_o   (mac8_ready),
    .op_i              (op),
    .operand_a_i       (operand_a),
    .operand_b_i       (operand_b),
    .trans_id_i        (trans_id),
    .result_valid_o    (result_valid),
    .result_o          (result),
    .result_trans_id_o (result_trans_id)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Writeback monitor samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (result_valid) begin
      q_data.push_back(result);
      q_id.push_back(result_trans_id);
      q_cyc.push_back(cyc);
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op_v, input logic [XLEN-1:0] a_v,
                               input logic [XLEN-1:0] b_v, input logic [TID-1:0] id_v);
    mac8_valid = 1'b1;
    op         = op_v;
    operand_a  = a_v;
    operand_b  = b_v;
    trans_id   = id_v;
    @(posedge clk);
    #1;
    iss_cyc.push_back(cyc);
    mac8_valid = 1'b0;
  endtask

  task automatic popCheck(input string tag, input logic [XLEN-1:0] exp_data, input logic [TID-1:0] exp_id);
    logic [XLEN-1:0] d;
    logic [TID-1:0]  id;
    int              c;
    int              ic;
    checkOutput({tag, "_present"}, 64'(q_data.size() != 0), 64'd1);
    if (q_data.size() != 0 && iss_cyc.size() != 0) begin
      d  = q_data.pop_front();
      id = q_id.pop_front();
      c  = q_cyc.pop_front();
      ic = iss_cyc.pop_front();
      checkOutput({tag, "_data"}, 64'(d), 64'(exp_data));
      checkOutput({tag, "_id"}, 64'(id), 64'(exp_id));
      checkOutput({tag, "_latency"}, 64'(c - ic), 64'd2);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    flush      = 1'b0;
    mac8_valid = 1'b0;
    op         = OP_DOT8;
    operand_a  = '0;
    operand_b  = '0;
    trans_id   = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_valid", 64'(result_valid), 64'd0);
    checkOutput("reset_result", 64'(result), 64'd0);
    checkOutput("reset_id", 64'(result_trans_id), 64'd0);
    checkOutput("reset_ready", 64'(mac8_ready), 64'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("ready_after_reset", 64'(mac8_ready), 64'd1);
    stepCycles(1);

    // Basic DOT8 with explicit cycle-by-cycle latency and hold checks
    applyStimulus(OP_DOT8, 32'h01020304, 32'h01010101, 3'd5);
    stepCycles(1);
    checkOutput("dot8_not_early", 64'(result_valid), 64'd0);
    stepCycles(1);
    checkOutput("dot8_valid", 64'(result_valid), 64'd1);
    checkOutput("dot8_result", 64'(result), 64'h0000000A);
    checkOutput("dot8_id", 64'(result_trans_id), 64'd5);
    stepCycles(1);
    checkOutput("dot8_single_strobe", 64'(result_valid), 64'd0);
    checkOutput("dot8_result_hold", 64'(result), 64'h0000000A);
    popCheck("dot8", 32'h0000000A, 3'd5);
    applyStimulus(OP_RDACC, 32'h0, 32'h0, 3'd6);
    stepCycles(3);
    popCheck("acc_after_dot8", 32'h0, 3'd6);

    // Sign and extremes
    applyStimulus(OP_DOT8, 32'h80808080, 32'h80808080, 3'd1);
    applyStimulus(OP_DOT8, 32'hFFFFFFFF, 32'h01010101, 3'd2);
    stepCycles(3);
    popCheck("dot8_min_sq", 32'h00010000, 3'd1);
    popCheck("dot8_neg", 32'hFFFFFFFC, 3'd2);

    // Back-to-back MAC8 chain then RDACC
    applyStimulus(OP_MAC8, 32'h01020304, 32'h01010101, 3'd0);
    applyStimulus(OP_MAC8, 32'h01020304, 32'h01010101, 3'd1);
    applyStimulus(OP_MAC8, 32'h01020304, 32'h01010101, 3'd2);
    applyStimulus(OP_RDACC, 32'h0, 32'h0, 3'd3);
    stepCycles(3);
    popCheck("chain0", 32'd10, 3'd0);
    popCheck("chain1", 32'd20, 3'd1);
    popCheck("chain2", 32'd30, 3'd2);
    popCheck("chain_rd", 32'd30, 3'd3);

    // Accumulator wrap and clear
    applyStimulus(OP_CLRACC, 32'h0, 32'h0, 3'd4);
    applyStimulus(OP_MAC8, 32'hFFFFFFFF, 32'h00000001, 3'd5);
    applyStimulus(OP_MAC8, 32'h00000001, 32'h00000001, 3'd6);
    applyStimulus(OP_MAC8, 32'h01020304, 32'h01010101, 3'd7);
    applyStimulus(OP_CLRACC, 32'h12345678, 32'h9ABCDEF0, 3'd0);
    applyStimulus(OP_RDACC, 32'h0, 32'h0, 3'd1);
    stepCycles(3);
    popCheck("clr_old30", 32'd30, 3'd4);
    popCheck("mac_to_neg1", 32'hFFFFFFFF, 3'd5);
    popCheck("mac_wrap", 32'h00000000, 3'd6);
    popCheck("mac_after_wrap", 32'd10, 3'd7);
    popCheck("clr_old10", 32'd10, 3'd0);
    popCheck("rd_after_clr", 32'd0, 3'd1);

    // Flush kills two in-flight MAC8s and a same-cycle issue
    applyStimulus(OP_MAC8, 32'h01020304, 32'h01010101, 3'd2);
    stepCycles(3);
    popCheck("pre_flush_mac", 32'd10, 3'd2);
    mac8_valid = 1'b1;
    op         = OP_MAC8;
    operand_a  = 32'h80808080;
    operand_b  = 32'h80808080;
    trans_id   = 3'd1;
    stepCycles(1);
    trans_id   = 3'd2;
    stepCycles(1);
    trans_id   = 3'd3;
    flush      = 1'b1;
    stepCycles(1);
    mac8_valid = 1'b0;
    flush      = 1'b0;
    stepCycles(4);
    checkOutput("flush_no_result", 64'(q_data.size()), 64'd0);
    q_data.delete();
    q_id.delete();
    q_cyc.delete();
    applyStimulus(OP_RDACC, 32'h0, 32'h0, 3'd4);
    stepCycles(3);
    popCheck("rd_after_flush", 32'd10, 3'd4);

    // Reset asserted mid-pipe
    mac8_valid = 1'b1;
    op         = OP_MAC8;
    operand_a  = 32'h01020304;
    operand_b  = 32'h01010101;
    trans_id   = 3'd5;
    stepCycles(1);
    mac8_valid = 1'b0;
    stepCycles(1);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_valid", 64'(result_valid), 64'd0);
    checkOutput("midreset_result", 64'(result), 64'd0);
    checkOutput("midreset_id", 64'(result_trans_id), 64'd0);
    checkOutput("midreset_ready", 64'(mac8_ready), 64'd0);
    stepCycles(2);
    rst_n = 1'b1;
    #1;
    checkOutput("ready_after_midreset", 64'(mac8_ready), 64'd1);
    stepCycles(3);
    checkOutput("midreset_no_result", 64'(q_data.size()), 64'd0);
    q_data.delete();
    q_id.delete();
    q_cyc.delete();
    applyStimulus(OP_RDACC, 32'h0, 32'h0, 3'd7);
    stepCycles(3);
    popCheck("rd_after_midreset", 32'd0, 3'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
